avr_prefetch: RTL
=================

# avr_prefetch

Instruction prefetch stage between the synchronous program ROM and the fetch/decode path of the AVR core. It issues sequential program-memory reads and buffers returned words, each tagged with its PC, in a small FIFO. It presents them to the decoder through a valid/ready handshake. A redirect from the core (jump, call, return) flushes all buffered and in-flight words and restarts fetching at the target with no dead request cycle.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- PC_W, 16: program-counter / ROM address width.
- RESET_PC, 16'h0000: first fetch address after reset.
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- redirect  in  1  flush and restart fetch at redirect_pc this cycle.
- redirect_pc  in  PC_W  absolute target word address.
- prog_req  out  1  ROM read enable.
- prog_addr  out  PC_W  ROM word address.
- prog_data  in  16  ROM data; valid exactly one cycle after prog_req.
- instr  out  16  head-of-queue instruction word.
- instr_pc  out  PC_W  word address of instr.
- instr_valid  out  1  head entry present.
- instr_ready  in  1  decoder consumes head (driven as !stall).
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- State:
  - fetch_pc: next sequential address.
  - inflight: 1 bit, a request was issued last cycle.
  - inflight_pc: address of that request.
  - FIFO of {pc, instr}, with rd/wr pointers and count.
- Issue rule: prog_req = redirect | (count + inflight < DEPTH). The check is conservative and ignores a same-cycle pop.
- prog_addr = redirect ? redirect_pc : fetch_pc.
- On issue: fetch_pc <= prog_addr + 1, modulo 2^PC_W; inflight <= 1; inflight_pc <= prog_addr. Otherwise inflight <= 0.
- Response: when inflight is set and no redirect occurs this cycle, {inflight_pc, prog_data} is written to the FIFO tail at the clock edge.
- Pop: instr_valid & instr_ready & !redirect advances rd pointer.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Redirect, highest priority:
  - count <= 0 and pointers reset.
  - Any in-flight response arriving this cycle is discarded.
  - Any same-cycle pop is ignored.
  - A new request to redirect_pc is issued in the same cycle.
- Outputs:
  - instr_valid = (count != 0). It is combinational from state only, never from instr_ready.
  - instr and instr_pc come from FIFO head storage.
  - When the FIFO is empty, instr = 16'h0000 (NOP) and instr_pc = 0.
- Overflow is impossible by construction. The bench asserts that a write never occurs with count == DEPTH unless a pop occurs in the same cycle.

## Timing
- Reset values, asserted asynchronously:
  - prog_req 0, prog_addr RESET_PC.
  - instr_valid 0, instr 16'h0000, instr_pc 0, level 0.
  - fetch_pc RESET_PC, inflight 0.
- First cycle after RST deasserts: prog_req 1 at RESET_PC.
- Latency:
  - Request in cycle N → ROM data in cycle N+1 → instr_valid in cycle N+2.
  - Redirect-to-first-valid is therefore 2 cycles.
- Throughput: one instruction per cycle with instr_ready held high. Steady state is count=1, inflight=1.
- Backpressure: with instr_ready low, fetching continues until count + inflight == DEPTH. prog_req then drops. It resumes in the cycle after the first pop brings count + inflight below DEPTH.
- Redirect held for multiple cycles: each cycle flushes again and reissues at the current redirect_pc.
- RST asserted mid-operation: everything returns immediately to reset values. Any pending ROM response is ignored, because inflight is cleared.
- PC wrap: 16'hFFFF is followed by 16'h0000, with no special handling.

## Structure
- Shared package avr_pkg holds:
  - NOP encoding 16'h0000.
  - PC_W default.
  - pc_src encodings used by the fetch path.
- Sub-module avr_sync_fifo: parameterised width (PC_W+16) and DEPTH, with push/pop/flush, count and head outputs. Flush takes priority over push and pop.
- avr_prefetch holds only fetch_pc, the inflight tracking, and the issue/redirect logic.

## Test plan
- Reset: hold RST high with random prog_data → outputs at reset values. After release, prog_addr sequence 0,1,2… and the first instr_valid arrives 2 cycles after release with instr_pc=0.
- Streaming: ROM returns data = addr ^ 16'hA5A5, instr_ready=1 → one instr per cycle, instr_pc consecutive, instr matches, level stays ≤1.
- Backpressure, DEPTH=4: instr_ready=0 → exactly 4 requests issued, then prog_req=0 and level=4. Raise instr_ready for one cycle → exactly one new request.
- Redirect with in-flight data: level=3, inflight=1, redirect to 16'h0100 → level=0 next cycle. The stale response is dropped. The next valid instr has instr_pc=16'h0100, 2 cycles after the redirect.
- Redirect coincident with pop: instr_ready=1 and redirect=1 in the same cycle → no extra pop counted, FIFO empty, fetch resumes at target.
- Wrap: redirect to 16'hFFFE → instr_pc sequence FFFE, FFFF, 0000, 0001.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared definitions for the AVR fetch path: NOP encoding, default PC width
// and the program-counter source select used when forming the ROM address.
package avr_pkg;

    localparam int          PC_W_DEF = 16;
    localparam logic [15:0] NOP      = 16'h0000;

    typedef enum logic {
        PC_SRC_SEQ      = 1'b0,
        PC_SRC_REDIRECT = 1'b1
    } pc_src_e;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/avr_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; flush wins over push and pop.
// The head entry is read combinationally so it is visible the cycle after it is written.
module avr_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok = push;
        pop_ok  = pop && (count_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            push_ok = 1'b0;
            pop_ok  = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + AW'(1);
            if (pop_ok)  rd_d = rd_q + AW'(1);
            if (push_ok && !pop_ok)
                count_d = count_q + CW'(1);
            else if (!push_ok && pop_ok)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale contents are masked by the count downstream.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem[rd_q];

endmodule

// File: rtl/avr_prefetch.sv
// Instruction prefetch: sequential ROM reads tagged with their PC, buffered in a
// small FIFO and handed to the decoder; a redirect flushes and refetches at once.
module avr_prefetch
    import avr_pkg::*;
#(
    parameter int             DEPTH    = 4,
    parameter int             PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     prog_req,
    output logic [PC_W-1:0]          prog_addr,
    input  logic [15:0]              prog_data,
    output logic [15:0]              instr,
    output logic [PC_W-1:0]          instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int LW = level_width(DEPTH);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    pc_src_e            pc_src;
    logic               issue;
    logic [LW:0]        occupancy;
    logic [LW-1:0]      count;
    logic [PC_W+15:0]   head;

    always_comb begin
        pc_src    = (redirect && !RST) ? PC_SRC_REDIRECT : PC_SRC_SEQ;
        // Counts the outstanding request but not a same-cycle pop: conservative by design.
        occupancy = {1'b0, count} + {{LW{1'b0}}, inflight_q};
        issue     = !RST && ((pc_src == PC_SRC_REDIRECT) || (occupancy < (LW+1)'(DEPTH)));
        prog_addr = (pc_src == PC_SRC_REDIRECT) ? redirect_pc : fetch_pc_q;
        prog_req  = issue;

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (issue) begin
            fetch_pc_d    = prog_addr + PC_W'(1);
            inflight_pc_d = prog_addr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    avr_sync_fifo #(
        .WIDTH (PC_W + 16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .flush     (redirect),
        .push      (inflight_q && !redirect),
        .push_data ({inflight_pc_q, prog_data}),
        .pop       (instr_ready && !redirect),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        instr_valid = (count != '0);
        instr       = instr_valid ? head[15:0] : NOP;
        instr_pc    = instr_valid ? head[PC_W+15:16] : '0;
        level       = count;
    end

endmodule
